// File: rtl/mem_wb_stage.sv
// =============================================================================
// mem_wb_stage: MEM/WB pipeline register with write-back select, bubble on SRAM stall,
// and retire/stall performance counters.  Rev 1.0
// =============================================================================
`default_nettype none

module mem_wb_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ready,
   input  logic [31:0]      PC_in,
   input  logic             WB_en_in,
   input  logic             Mem_R_en_in,
   input  logic             Mem_W_en_in,
   input  logic [31:0]      ALU_result_in,
   input  logic [31:0]      Data_mem_in,
   input  logic [3:0]       Dest_in,
   output logic [31:0]      PC,
   output logic             WB_en,
   output logic [3:0]       WB_Dest,
   output logic [31:0]      WB_Value,
   output logic             Mem_R_en,
   output logic [CNT_W-1:0] retired_count,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q,       pc_d;
   logic             wb_en_q,    wb_en_d;
   logic             mem_r_en_q, mem_r_en_d;
   logic [31:0]      alu_q,      alu_d;
   logic [31:0]      data_q,     data_d;
   logic [3:0]       dest_q,     dest_d;
   logic [CNT_W-1:0] retired_q,  retired_d;
   logic [CNT_W-1:0] stall_q,    stall_d;

   always_comb begin
      pc_d       = pc_q;
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      alu_d      = alu_q;
      data_d     = data_q;
      dest_d     = dest_q;
      retired_d  = retired_q;
      stall_d    = stall_q;
      if (ready) begin
         pc_d       = PC_in;
         wb_en_d    = WB_en_in;
         mem_r_en_d = Mem_R_en_in;
         alu_d      = ALU_result_in;
         data_d     = Data_mem_in;
         dest_d     = Dest_in;
         if (WB_en_in || Mem_W_en_in)
            retired_d = retired_q + C_CNT_ONE;
      end else begin
         // Bubble: enables drop, payload holds, and SRAM data is never sampled.
         stall_d = stall_q + C_CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q       <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         alu_q      <= '0;
         data_q     <= '0;
         dest_q     <= '0;
         retired_q  <= '0;
         stall_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         wb_en_q    <= wb_en_d;
         mem_r_en_q <= mem_r_en_d;
         alu_q      <= alu_d;
         data_q     <= data_d;
         dest_q     <= dest_d;
         retired_q  <= retired_d;
         stall_q    <= stall_d;
      end
   end

   assign PC            = pc_q;
   assign WB_en         = wb_en_q;
   assign WB_Dest       = dest_q;
   assign WB_Value      = mem_r_en_q ? data_q : alu_q;
   assign Mem_R_en      = mem_r_en_q;
   assign retired_count = retired_q;
   assign stall_count   = stall_q;

endmodule

`default_nettype wire
